// File: rtl/msgpass_rd_addr_gen_pkg.sv
// msgPass_config_pkg: shared sizing and FSM state type for the message-pass read-address generator.
package msgPass_config_pkg;
    localparam int MSGPASS_BUFF_ADDR_WIDTH    = 4;
    localparam int MSGPASS_RDGEN_CH_NUM       = 2;
    localparam int MSGPASS_RDGEN_STRIDE_WIDTH = 2;

    typedef enum logic {IDLE, RUN} rdgen_state_t;
endpackage

// File: rtl/msgpass_rd_addr_chan.sv
// msgpass_rd_addr_chan: one read channel walking [base, last] with stride, optional looping and DRC hold.
module msgpass_rd_addr_chan
    import msgPass_config_pkg::*;
#(
    parameter int ADDR_WIDTH   = MSGPASS_BUFF_ADDR_WIDTH,
    parameter int STRIDE_WIDTH = MSGPASS_RDGEN_STRIDE_WIDTH
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [ADDR_WIDTH-1:0]   baseAddr,
    input  logic [ADDR_WIDTH-1:0]   lastAddr,
    input  logic [STRIDE_WIDTH-1:0] stride,
    input  logic                    loopEn,
    input  logic                    isDrc,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic                    addrVld,
    output logic                    busy,
    output logic                    done,
    output logic                    cfgErr
);
    localparam int AW1 = ADDR_WIDTH + 1;

    rdgen_state_t            state;
    logic [ADDR_WIDTH-1:0]   baseQ;
    logic [ADDR_WIDTH-1:0]   lastQ;
    logic [STRIDE_WIDTH-1:0] strideQ;
    logic                    loopQ;
    logic [ADDR_WIDTH:0]     nxt;

    // One extra bit so an overshoot past 2^ADDR_WIDTH ends the pass instead of wrapping
    assign nxt = AW1'(addr) + AW1'(strideQ) + AW1'(1);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            addrVld <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfgErr  <= 1'b0;
            baseQ   <= '0;
            lastQ   <= '0;
            strideQ <= '0;
            loopQ   <= 1'b0;
        end else begin
            done   <= 1'b0;
            cfgErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        baseQ   <= baseAddr;
                        lastQ   <= lastAddr;
                        strideQ <= stride;
                        loopQ   <= loopEn;
                        if (baseAddr <= lastAddr) begin
                            state   <= RUN;
                            addr    <= baseAddr;
                            addrVld <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            cfgErr <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        addrVld <= 1'b0;
                        busy    <= 1'b0;
                    end else if (!isDrc) begin
                        if (nxt <= {1'b0, lastQ}) begin
                            addr <= nxt[ADDR_WIDTH-1:0];
                        end else if (loopQ) begin
                            addr <= baseQ;
                        end else begin
                            state   <= IDLE;
                            addrVld <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/msgpass_rd_addr_gen.sv
// msgpass_rd_addr_gen: CH_NUM independent read-address channels feeding the message-pass buffer read ports.
module msgpass_rd_addr_gen
    import msgPass_config_pkg::*;
#(
    parameter int ADDR_WIDTH   = MSGPASS_BUFF_ADDR_WIDTH,
    parameter int CH_NUM       = MSGPASS_RDGEN_CH_NUM,
    parameter int STRIDE_WIDTH = MSGPASS_RDGEN_STRIDE_WIDTH
) (
    input  logic                           sys_clk,
    input  logic                           rst,
    input  logic [CH_NUM-1:0]              start_i,
    input  logic [CH_NUM-1:0]              stop_i,
    input  logic [CH_NUM*ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [CH_NUM*ADDR_WIDTH-1:0]   last_addr_i,
    input  logic [CH_NUM*STRIDE_WIDTH-1:0] stride_i,
    input  logic [CH_NUM-1:0]              loop_en_i,
    input  logic [CH_NUM-1:0]              is_drc_i,
    output logic [CH_NUM*ADDR_WIDTH-1:0]   addr_o,
    output logic [CH_NUM-1:0]              addr_vld_o,
    output logic [CH_NUM-1:0]              busy_o,
    output logic [CH_NUM-1:0]              done_o,
    output logic [CH_NUM-1:0]              cfg_err_o
);
    for (genvar c = 0; c < CH_NUM; c++) begin : gCh
        msgpass_rd_addr_chan #(
            .ADDR_WIDTH  (ADDR_WIDTH),
            .STRIDE_WIDTH(STRIDE_WIDTH)
        ) uChan (
            .sys_clk (sys_clk),
            .rst     (rst),
            .start   (start_i[c]),
            .stop    (stop_i[c]),
            .baseAddr(base_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .lastAddr(last_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .stride  (stride_i[c*STRIDE_WIDTH +: STRIDE_WIDTH]),
            .loopEn  (loop_en_i[c]),
            .isDrc   (is_drc_i[c]),
            .addr    (addr_o[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .addrVld (addr_vld_o[c]),
            .busy    (busy_o[c]),
            .done    (done_o[c]),
            .cfgErr  (cfg_err_o[c])
        );
    end
endmodule
